conv_mac_accum: RTL
===================

Name: conv_mac_accum

Overview:
- Per-output-pixel multiply-accumulate stage for the CNN convolution datapath.
- Streams TAPS unsigned 8-bit activations against signed 8-bit weights, subtracts the input zero point from each activation, and adds a 32-bit bias.
- Presents the 64-bit signed accumulator on a valid/ready port. That port feeds the fixed-point requantization stage directly, which takes a 64-bit input.

Parameters:
- TAPS, 9, taps per output (3x3 kernel, one channel); legal range 1..1024.
- CNT_W, 10, tap counter width; must satisfy 2^CNT_W > TAPS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins an accumulation; honoured only in IDLE.
- bias  in  32  signed bias, sampled on the accepted start.
- in_zp  in  8  unsigned input zero point, sampled on the accepted start.
- px_valid  in  1  activation/weight beat valid.
- px_ready  out  1  high only in ACCUM.
- px_data  in  8  unsigned activation.
- wt_data  in  8  signed weight.
- acc_out  out  64  signed accumulator result.
- acc_valid  out  1  result valid.
- acc_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0. Outputs acc_out=0, acc_valid=0, px_ready=0, busy=0. Reset is honoured in every state; any partial sum is discarded.
- States: IDLE, ACCUM, DONE (plus DRAIN when the optional feature is enabled).
- IDLE -> ACCUM: on start.
  - acc <= sign-extended bias.
  - zp register <= in_zp.
  - cnt <= 0.
- ACCUM: px_ready=1. Each beat with px_valid&px_ready:
  - diff = {1'b0,px_data} - {1'b0,zp}, 9-bit signed, range -255..255.
  - prod = diff * wt_data, 17-bit signed.
  - acc <= acc + sign-extended prod.
  - cnt <= cnt+1.
- Bubbles (px_valid=0) do not change acc or cnt.
- ACCUM -> DONE: on the accepted beat with cnt==TAPS-1.
  - acc_valid rises on the next cycle.
  - acc_out = acc (registered).
- DONE:
  - acc_out and acc_valid are held stable until acc_ready=1.
  - On the acc_valid&acc_ready cycle, the next state is IDLE and acc_valid falls the following cycle.
  - acc_ready while not valid has no effect.
- start outside IDLE is ignored; there is no queueing.
- Back-to-back results: start may be asserted in the cycle after the handshake (IDLE).
- Latency: start accepted at cycle 0; with px_valid held high, beats are accepted at cycles 1..TAPS and acc_valid=1 at cycle TAPS+1.
- No overflow is possible. Worst case is |1024*255*128 + 2^31| < 2^63, so no saturation logic is required.
- acc_out is two's complement and is consumed unchanged by the requantizer.

Optional Feature:
- Macro: CONV_MAC_PIPE_EN.
- Defined:
  - diff*wt is registered in a product register with its own valid bit; the accumulate happens one cycle later.
  - After the last accepted beat, the FSM enters DRAIN for one cycle so the final product is added, then DONE.
  - acc_valid therefore arrives at cycle TAPS+2.
  - rst clears the product register and its valid bit.
- Undefined: single-cycle multiply-accumulate as described above; no DRAIN state.
- The numerical result is identical in both builds.

Test Plan:
1. TAPS=9, bias=0, zp=0, px=1, wt=1 every beat, continuous valid -> acc_out=64'd9; acc_valid at cycle 10 (11 with CONV_MAC_PIPE_EN).
2. bias=-100, zp=0, px=255, wt=-128 x9 -> acc_out=64'hFFFF_FFFF_FFFB_841C (-293860).
3. bias=1000, zp=12, px=10, wt=3 x9 -> each product -6 -> acc_out=64'd946.
4. Case 1 with a px_valid bubble after every beat -> acc_out=9; px_ready stays high throughout ACCUM; exactly 9 beats consumed.
5. Result ready, hold acc_ready=0 for 5 cycles while pulsing start -> acc_valid and acc_out stay stable, start is ignored. Raise acc_ready -> one handshake; acc_valid=0 and busy=0 the next cycle.
6. rst pulsed after 4 accepted beats -> next cycle acc_valid=0, busy=0, acc_out=0, px_ready=0. A new start followed by case 1 stimulus -> acc_out=9 (no residue).

Source files
------------

// File: rtl/conv_mac_accum_if.sv
// conv_mac_accum_if: control, pixel/weight stream and result handshake for the convolution MAC stage.
interface conv_mac_accum_if;
  logic        start;
  logic [31:0] bias;
  logic [7:0]  in_zp;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_data;
  logic [7:0]  wt_data;
  logic [63:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;

  modport master (
    output start, bias, in_zp, px_valid, px_data, wt_data, acc_ready,
    input  px_ready, acc_out, acc_valid, busy
  );

  modport slave (
    input  start, bias, in_zp, px_valid, px_data, wt_data, acc_ready,
    output px_ready, acc_out, acc_valid, busy
  );
endinterface

// File: rtl/conv_mac_accum.sv
// conv_mac_accum: per-output-pixel MAC with zero-point subtraction and bias preload, 64-bit result on valid/ready.
// Optional macro CONV_MAC_PIPE_EN registers the product and inserts a one-cycle DRAIN state.
module conv_mac_accum #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned CNT_W = 10
) (
  input logic             clk,
  input logic             rst,
  conv_mac_accum_if.slave bus
);
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned DIFF_W = 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
`ifdef CONV_MAC_PIPE_EN
    ,DRAIN = 2'd3
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]                zp_q, zp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      acc_valid_q, acc_valid_d;
  logic                      px_ready_q, px_ready_d;
  logic                      busy_q, busy_d;
`ifdef CONV_MAC_PIPE_EN
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
`endif

  logic                      beat_c;
  logic                      last_c;
  logic signed [DIFF_W-1:0]  diff_c;
  logic signed [PROD_W-1:0]  diff_x_c;
  logic signed [PROD_W-1:0]  wt_x_c;
  logic signed [PROD_W-1:0]  prod_c;

  // Beat qualification and the zero-point-corrected product; 17 bits holds +/-255*128 exactly.
  always_comb begin
    beat_c   = px_ready_q && bus.px_valid;
    last_c   = beat_c && (cnt_q == LAST_CNT);
    diff_c   = DIFF_W'({1'b0, bus.px_data}) - DIFF_W'({1'b0, zp_q});
    diff_x_c = PROD_W'(diff_c);
    wt_x_c   = PROD_W'($signed(bus.wt_data));
    prod_c   = diff_x_c * wt_x_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = ACCUM;
`ifdef CONV_MAC_PIPE_EN
      ACCUM: if (last_c) state_d = DRAIN;
      DRAIN: state_d = DONE;
`else
      ACCUM: if (last_c) state_d = DONE;
`endif
      DONE:  if (bus.acc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_d       = acc_q;
    zp_d        = zp_q;
    cnt_d       = cnt_q;
    acc_valid_d = (state_d == DONE);
    px_ready_d  = (state_d == ACCUM);
    busy_d      = (state_d != IDLE);
`ifdef CONV_MAC_PIPE_EN
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
`endif
    if ((state_q == IDLE) && bus.start) begin
      acc_d = ACC_W'($signed(bus.bias));
      zp_d  = bus.in_zp;
      cnt_d = '0;
    end
`ifdef CONV_MAC_PIPE_EN
    // Product registered one cycle earlier lands here; DRAIN exists to absorb the final one.
    if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);
    if (beat_c) begin
      prod_d     = prod_c;
      prod_vld_d = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
    end
`else
    if (beat_c) begin
      acc_d = acc_q + ACC_W'(prod_c);
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      zp_q        <= '0;
      cnt_q       <= '0;
      acc_valid_q <= 1'b0;
      px_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CONV_MAC_PIPE_EN
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      zp_q        <= zp_d;
      cnt_q       <= cnt_d;
      acc_valid_q <= acc_valid_d;
      px_ready_q  <= px_ready_d;
      busy_q      <= busy_d;
`ifdef CONV_MAC_PIPE_EN
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
`endif
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.px_ready  = px_ready_q;
  assign bus.busy      = busy_q;

endmodule
